// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch stage and the instruction memory.
// The fetch stage drives the request and address; the memory answers with
// ready and the instruction word in the same cycle it has data.
interface instr_fetch_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdy,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdy,
        output mem_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the 16-bit pipeline.
// Owns the PC, reads one word at a time from a variable-latency memory,
// presents it to decode until decode accepts it, then advances by 2.
// Redirects reload the PC; a HALT opcode, a memory timeout or a misaligned
// redirect target stop fetching until reset.
module instr_fetch #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          TO_BITS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      mem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    output logic [15:0]        instr,
    output logic               instr_valid,
    output logic [15:0]        pc_plus2,
    output logic [2:0]         pc_top,
    output logic               halted,
    output logic               err
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // The wait counter gives up on the edge where it would reach its maximum,
    // so the request is visible for exactly 2**TO_BITS-1 cycles.
    localparam logic [TO_BITS-1:0] WAIT_LIMIT = ~(TO_BITS'(1));

    state_t               state_q;
    logic [15:0]          pc_q;
    logic [15:0]          pc_d;
    logic [15:0]          instr_q;
    logic                 valid_q;
    logic                 mem_rd_q;
    logic                 halted_q;
    logic                 err_q;
    logic [TO_BITS-1:0]   wait_q;
    logic                 isHalt;

    assign pc_d   = pc_q + 16'd2;
    assign isHalt = (instr_q[15:11] == 5'b00000);

    // Fetch sequencer: redirect beats stall, memory ready and timeout;
    // the halted state is left only through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_RESET;
            instr_q  <= 16'h0000;
            valid_q  <= 1'b0;
            mem_rd_q <= 1'b1;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else if (state_q != S_HALTED && redirect) begin
            valid_q <= 1'b0;
            wait_q  <= '0;
            if (redirect_pc[0]) begin
                err_q    <= 1'b1;
                state_q  <= S_HALTED;
                mem_rd_q <= 1'b0;
            end else begin
                pc_q     <= redirect_pc;
                state_q  <= S_FETCH;
                mem_rd_q <= 1'b1;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem.mem_rdy) begin
                        instr_q  <= mem.mem_data;
                        wait_q   <= '0;
                        state_q  <= S_HOLD;
                        mem_rd_q <= 1'b0;
                        valid_q  <= 1'b1;
                    end else if (wait_q == WAIT_LIMIT) begin
                        err_q    <= 1'b1;
                        wait_q   <= '0;
                        state_q  <= S_HALTED;
                        mem_rd_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + TO_BITS'(1);
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (isHalt) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                            mem_rd_q <= 1'b0;
                        end else begin
                            pc_q     <= pc_d;
                            state_q  <= S_FETCH;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    mem_rd_q <= 1'b0;
                    valid_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_HALTED;
                    mem_rd_q <= 1'b0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign pc_plus2     = pc_d;
    assign pc_top       = pc_q[15:13];
    assign halted       = halted_q;
    assign err          = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Memory responses are pushed onto a
// scoreboard queue when driven and popped when decode sees them presented.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic [15:0] instr;
    logic        instrValid;
    logic [15:0] pcPlus2;
    logic [2:0]  pcTop;
    logic        halted;
    logic        err;

    int          checks;
    int          failures;
    logic [15:0] sb[$];
    logic [15:0] expInstr;

    instr_fetch_if memIf ();

    instr_fetch #(
        .PC_RESET (16'h0000),
        .TO_BITS  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (memIf),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .instr       (instr),
        .instr_valid (instrValid),
        .pc_plus2    (pcPlus2),
        .pc_top      (pcTop),
        .halted      (halted),
        .err         (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset;
        rst              = 1'b1;
        stall            = 1'b0;
        redirect         = 1'b0;
        redirectPc       = 16'h0000;
        memIf.mem_rdy    = 1'b0;
        memIf.mem_data   = 16'hDEAD;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic memRespond(input logic [15:0] data);
        memIf.mem_rdy  = 1'b1;
        memIf.mem_data = data;
        sb.push_back(data);
        tick();
        memIf.mem_rdy  = 1'b0;
        memIf.mem_data = 16'hDEAD;
    endtask

    task automatic test_reset;
        applyReset();
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instrValid); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0000", instr); end
        checks++; if (halted !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b%b exp=00", halted, err); end
        checks++; if (memIf.mem_rd !== 1'b1 || memIf.mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_req got=%b/%h exp=1/0000", memIf.mem_rd, memIf.mem_addr); end
    endtask

    task automatic test_first_fetch;
        for (int i = 0; i < 2; i++) begin
            checks++; if (memIf.mem_rd !== 1'b1 || memIf.mem_addr !== 16'h0000 || instrValid !== 1'b0) begin failures++; $display("[TB] FAIL first_wait got=%b/%h/%b exp=1/0000/0", memIf.mem_rd, memIf.mem_addr, instrValid); end
            tick();
        end
        memRespond(16'hC123);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL first_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr || instrValid !== 1'b1) begin failures++; $display("[TB] FAIL first_instr got=%h/%b exp=%h/1", instr, instrValid, expInstr); end end
        checks++; if (pcPlus2 !== 16'h0002 || pcTop !== 3'b000) begin failures++; $display("[TB] FAIL first_pc got=%h/%b exp=0002/000", pcPlus2, pcTop); end
        checks++; if (memIf.mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL first_rd got=%b exp=0", memIf.mem_rd); end
    endtask

    task automatic test_stall;
        applyReset();
        stall = 1'b1;
        memRespond(16'h4A21);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL stall_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr) begin failures++; $display("[TB] FAIL stall_instr got=%h exp=%h", instr, expInstr); end end
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr !== 16'h4A21 || instrValid !== 1'b1 || memIf.mem_rd !== 1'b0 || pcPlus2 !== 16'h0002) begin failures++; $display("[TB] FAIL stall_hold%0d got=%h/%b/%b/%h exp=4a21/1/0/0002", i, instr, instrValid, memIf.mem_rd, pcPlus2); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        checks++; if (memIf.mem_rd !== 1'b1 || memIf.mem_addr !== 16'h0002 || instrValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release got=%b/%h/%b exp=1/0002/0", memIf.mem_rd, memIf.mem_addr, instrValid); end
    endtask

    task automatic test_redirect;
        redirect       = 1'b1;
        redirectPc     = 16'hE010;
        memIf.mem_rdy  = 1'b1;
        memIf.mem_data = 16'h1111;
        tick();
        redirect       = 1'b0;
        memIf.mem_rdy  = 1'b0;
        memIf.mem_data = 16'hDEAD;
        checks++; if (instrValid !== 1'b0 || instr === 16'h1111) begin failures++; $display("[TB] FAIL redir_drop got=%h/%b exp=not1111/0", instr, instrValid); end
        checks++; if (memIf.mem_rd !== 1'b1 || memIf.mem_addr !== 16'hE010) begin failures++; $display("[TB] FAIL redir_addr got=%b/%h exp=1/e010", memIf.mem_rd, memIf.mem_addr); end
        stall = 1'b1;
        memRespond(16'h8ACE);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL redir_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr || instrValid !== 1'b1) begin failures++; $display("[TB] FAIL redir_instr got=%h/%b exp=%h/1", instr, instrValid, expInstr); end end
        checks++; if (pcTop !== 3'b111 || pcPlus2 !== 16'hE012) begin failures++; $display("[TB] FAIL redir_pc got=%b/%h exp=111/e012", pcTop, pcPlus2); end
        stall = 1'b0;
    endtask

    task automatic test_wrap_halt;
        redirect   = 1'b1;
        redirectPc = 16'hFFFE;
        tick();
        redirect   = 1'b0;
        checks++; if (memIf.mem_addr !== 16'hFFFE || memIf.mem_rd !== 1'b1 || instrValid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_redir got=%h/%b/%b exp=fffe/1/0", memIf.mem_addr, memIf.mem_rd, instrValid); end
        memRespond(16'h2000);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL wrap_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr) begin failures++; $display("[TB] FAIL wrap_instr got=%h exp=%h", instr, expInstr); end end
        checks++; if (pcPlus2 !== 16'h0000 || pcTop !== 3'b111) begin failures++; $display("[TB] FAIL wrap_pc got=%h/%b exp=0000/111", pcPlus2, pcTop); end
        tick();
        checks++; if (memIf.mem_addr !== 16'h0000 || memIf.mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL wrap_addr got=%h/%b exp=0000/1", memIf.mem_addr, memIf.mem_rd); end
        memRespond(16'h0000);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL halt_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr || instrValid !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_present got=%h/%b/%b exp=%h/1/0", instr, instrValid, halted, expInstr); end end
        tick();
        checks++; if (halted !== 1'b1 || instrValid !== 1'b0 || memIf.mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL halt_stop got=%b/%b/%b exp=1/0/0", halted, instrValid, memIf.mem_rd); end
        redirect   = 1'b1;
        redirectPc = 16'h0100;
        tick();
        redirect   = 1'b0;
        tick();
        checks++; if (halted !== 1'b1 || memIf.mem_rd !== 1'b0 || memIf.mem_addr !== 16'h0000 || err !== 1'b0) begin failures++; $display("[TB] FAIL halt_redir got=%b/%b/%h/%b exp=1/0/0000/0", halted, memIf.mem_rd, memIf.mem_addr, err); end
    endtask

    task automatic test_timeout;
        applyReset();
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++; if (err !== 1'b0 || memIf.mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL timeout_early%0d got=%b/%b exp=0/1", i, err, memIf.mem_rd); end
        end
        tick();
        checks++; if (err !== 1'b1 || memIf.mem_rd !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL timeout_err got=%b/%b/%b exp=1/0/0", err, memIf.mem_rd, halted); end
        memIf.mem_rdy  = 1'b1;
        memIf.mem_data = 16'h7777;
        tick();
        memIf.mem_rdy  = 1'b0;
        checks++; if (err !== 1'b1 || memIf.mem_rd !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("[TB] FAIL timeout_stay got=%b/%b/%b exp=1/0/0", err, memIf.mem_rd, instrValid); end
        applyReset();
        checks++; if (err !== 1'b0 || memIf.mem_rd !== 1'b1 || memIf.mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL timeout_reset got=%b/%b/%h exp=0/1/0000", err, memIf.mem_rd, memIf.mem_addr); end
    endtask

    task automatic test_misaligned;
        applyReset();
        stall = 1'b1;
        memRespond(16'h4A21);
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL mis_sb got=empty exp=entry"); end
        else begin expInstr = sb.pop_front(); if (instr !== expInstr) begin failures++; $display("[TB] FAIL mis_instr got=%h exp=%h", instr, expInstr); end end
        redirect   = 1'b1;
        redirectPc = 16'h0103;
        tick();
        redirect   = 1'b0;
        stall      = 1'b0;
        checks++; if (err !== 1'b1 || instrValid !== 1'b0 || memIf.mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL mis_err got=%b/%b/%b exp=1/0/0", err, instrValid, memIf.mem_rd); end
        checks++; if (memIf.mem_addr !== 16'h0000 || halted !== 1'b0) begin failures++; $display("[TB] FAIL mis_pc got=%h/%b exp=0000/0", memIf.mem_addr, halted); end
        tick();
        tick();
        checks++; if (memIf.mem_rd !== 1'b0 || err !== 1'b1) begin failures++; $display("[TB] FAIL mis_stay got=%b/%b exp=0/1", memIf.mem_rd, err); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectPc     = 16'h0000;
        memIf.mem_rdy  = 1'b0;
        memIf.mem_data = 16'hDEAD;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_wrap_halt();
        test_timeout();
        test_misaligned();
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the 16-bit pipeline; the upstream producer of the 16-bit instruction word and PC context consumed by the decode stage.
- Owns the PC register and issues word reads to a variable-latency instruction memory with a request/ready handshake.
- Presents one instruction at a time, held under a decode stall.
- Accepts branch/jump redirects, stops on HALT, and flags memory timeouts and misaligned redirect targets.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- TO_BITS, 4, width of the memory-wait counter; timeout at count 2**TO_BITS-1 (15 by default).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  16  read address, equals current PC.
- mem_rdy  in  1  memory data valid this cycle; meaningful only while mem_rd=1.
- mem_data  in  16  instruction word returned with mem_rdy.
- stall  in  1  decode cannot accept; hold the presented instruction.
- redirect  in  1  load a new PC (branch/jump taken).
- redirect_pc  in  16  target PC for redirect.
- instr  out  16  instruction presented to decode.
- instr_valid  out  1  instr, pc_plus2 and pc_top are valid.
- pc_plus2  out  16  address of presented instruction + 2, modulo 2^16.
- pc_top  out  3  bits [15:13] of presented instruction's PC, for jump address formation.
- halted  out  1  HALT retired; fetch stopped.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at edge), all outputs and state:
  - pc=PC_RESET, state=FETCH, instr=16'h0000, instr_valid=0, halted=0, err=0, wait counter=0.
  - Reset overrides every other input, in any state, including mid-request. A pending memory response is discarded.
- States: FETCH, HOLD, HALTED.
- FETCH:
  - mem_rd=1, mem_addr=pc, instr_valid=0. The wait counter increments each cycle without mem_rdy.
  - mem_rdy=1: instr<=mem_data, counter<=0, state<=HOLD. instr_valid rises the next cycle, so latency is 1 cycle from mem_rdy.
  - Counter reaches 2**TO_BITS-1 without mem_rdy: err<=1, state<=HALTED.
- HOLD:
  - mem_rd=0, instr_valid=1, and instr, pc_plus2, pc_top are stable.
  - stall=1: remain in HOLD with no output change.
  - stall=0, instr[15:11]≠5'b00000: pc<=pc+2 (16'hFFFE wraps to 16'h0000), state<=FETCH.
  - stall=0, instr[15:11]=5'b00000 (HALT): halted<=1, state<=HALTED. HALT is presented once to decode before stopping.
- HALTED:
  - mem_rd=0, instr_valid=0, and pc is frozen.
  - redirect and stall are ignored. Only rst exits this state.
- Redirect, FETCH or HOLD:
  - Highest priority after rst. Overrides stall, mem_rdy and timeout in the same cycle.
  - redirect_pc[0]=0: pc<=redirect_pc, counter<=0, state<=FETCH, instr_valid<=0 next cycle. A coincident mem_rdy is dropped, and a pending mem_data is never presented.
  - redirect_pc[0]=1 (misaligned): err<=1, state<=HALTED, pc unchanged.
- err and halted are sticky until rst. err=1 never coexists with a new fetch.
- pc_plus2 = pc+2, pc_top = pc[15:13], both combinational from pc; they are defined only while instr_valid=1.
- mem_addr is always even; pc[0] is never set except via reset parameter misuse, which is not supported.

Test Plan:
- Reset then first fetch:
  - Stimulus: rst 2 cycles; mem_rdy 2 cycles after release with mem_data=16'hC123.
  - Required: mem_addr=16'h0000, mem_rd=1 until mem_rdy; next cycle instr=16'hC123, instr_valid=1, pc_plus2=16'h0002, pc_top=3'b000.
- Stall hold:
  - Stimulus: in HOLD with instr=16'h4A21, stall=1 for 3 cycles, then 0.
  - Required: outputs unchanged and mem_rd=0 for 3 cycles; the cycle after release, mem_rd=1, mem_addr=16'h0002.
- Redirect collision:
  - Stimulus: in FETCH, redirect=1, redirect_pc=16'hE010, mem_rdy=1, mem_data=16'h1111, all in the same cycle.
  - Required: 16'h1111 is never presented; next mem_addr=16'hE010; after that fetch completes, pc_top=3'b111 and pc_plus2=16'hE012.
- Wrap and HALT:
  - Stimulus: redirect to 16'hFFFE, mem returns 16'h2000, stall=0; then mem returns 16'h0000.
  - Required: after the first instruction, mem_addr=16'h0000. After HALT is presented for 1 cycle, halted=1, mem_rd=0 permanently; a later redirect has no effect.
- Timeout:
  - Stimulus: hold mem_rdy=0 in FETCH.
  - Required: err=1 and halted state reached 15 cycles after the request starts; mem_rd=0 afterwards; rst clears err to 0 and restarts at PC_RESET.
- Misaligned redirect:
  - Stimulus: in HOLD, redirect_pc=16'h0103.
  - Required: err=1 next cycle, instr_valid=0, mem_rd stays 0, pc unchanged.
